// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types, ids and access legality check for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  // An access is legal when word aligned and it is not a CPU store into the
  // instruction region. The loader may write any aligned word.
  function automatic logic arb_is_legal(
    input logic [31:0] addr,
    input logic        we,
    input logic        id,
    input int unsigned ram_size_bit,
    input int unsigned inst_words
  );
    logic [31:0] word_idx;
    word_idx = (addr >> 2) & ((32'd1 << ram_size_bit) - 32'd1);
    return (addr[1:0] == 2'b00) && !((id == REQ_CPU) && we && (word_idx < inst_words));
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - one requester port of the memory arbiter
interface mem_port_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        done;
  logic        err;

  modport master (output req, we, addr, wdata, input gnt, done, err);
  modport slave  (input req, we, addr, wdata, output gnt, done, err);
endinterface

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// rtl/mem_port_arbiter_rr_arbiter2.sv - two-way round-robin / fixed-priority picker with last-grant register
module rr_arbiter2
  import mem_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,     // bit 0 = CPU, bit 1 = loader
  input  logic       i_take,    // arbitration edge: winner becomes the new last
  output logic       o_any,
  output logic       o_winner
);

  logic r_last;
  logic w_winner;

  // Single requester wins; a tie goes to the CPU or to whoever did not win last
  always_comb begin
    w_winner = REQ_CPU;
    if (i_req == 2'b10) begin
      w_winner = REQ_DBG;
    end else if (i_req == 2'b11) begin
      w_winner = FIXED_PRIO ? REQ_CPU : ~r_last;
    end
  end

  // Remember the last winner; reset value makes the CPU win the first tie
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last <= REQ_DBG;
    end else if (i_take && o_any) begin
      r_last <= w_winner;
    end
  end

  assign o_any    = |i_req;
  assign o_winner = w_winner;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises CPU and loader accesses onto the single-port unified memory
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned RAM_SIZE_BIT = 8,
  parameter int unsigned INST_WORDS   = 32,
  parameter bit          FIXED_PRIO   = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  mem_port_arbiter_if.slave        cpu,
  mem_port_arbiter_if.slave        dbg,
  output logic [31:0]              rdata,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic                     mem_read,
  output logic                     mem_write,
  input  logic [31:0]              mem_rdata
);

  arb_state_e  r_state;
  logic        r_we;
  logic        r_id;
  logic        r_legal;
  logic [1:0]  r_gnt;
  logic [1:0]  r_done;
  logic [1:0]  r_err;
  logic [31:0] r_rdata;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_mem_read;
  logic        r_mem_write;

  logic        w_take;
  logic        w_any;
  logic        w_winner;
  logic [1:0]  w_win_onehot;
  logic [1:0]  w_id_onehot;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_sel_we;
  logic        w_sel_legal;

  // New requests are only considered when no access is in flight
  assign w_take = (r_state == IDLE) || (r_state == RESP);

  rr_arbiter2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_rr_arbiter2 (
    .clk      (clk),
    .reset    (reset),
    .i_req    ({dbg.req, cpu.req}),
    .i_take   (w_take),
    .o_any    (w_any),
    .o_winner (w_winner)
  );

  assign w_sel_addr   = (w_winner == REQ_DBG) ? dbg.addr  : cpu.addr;
  assign w_sel_wdata  = (w_winner == REQ_DBG) ? dbg.wdata : cpu.wdata;
  assign w_sel_we     = (w_winner == REQ_DBG) ? dbg.we    : cpu.we;
  assign w_sel_legal  = arb_is_legal(w_sel_addr, w_sel_we, w_winner, RAM_SIZE_BIT, INST_WORDS);
  assign w_win_onehot = (w_winner == REQ_DBG) ? 2'b10 : 2'b01;
  assign w_id_onehot  = (r_id == REQ_DBG) ? 2'b10 : 2'b01;

  // Access sequencer: all outputs are registered so a single strobe cycle
  // lands exactly in ACCESS and done/err/rdata land exactly in RESP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_id        <= REQ_CPU;
      r_legal     <= 1'b0;
      r_gnt       <= 2'b00;
      r_done      <= 2'b00;
      r_err       <= 2'b00;
      r_rdata     <= 32'd0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else begin
      case (r_state)
        IDLE, RESP: begin
          r_done <= 2'b00;
          r_err  <= 2'b00;
          if (w_any) begin
            r_state     <= ACCESS;
            r_id        <= w_winner;
            r_we        <= w_sel_we;
            r_legal     <= w_sel_legal;
            r_gnt       <= w_win_onehot;
            r_mem_addr  <= w_sel_addr;
            r_mem_read  <= w_sel_legal & ~w_sel_we;
            r_mem_write <= w_sel_legal & w_sel_we;
            if (w_sel_legal) begin
              r_mem_wdata <= w_sel_wdata;
            end
          end else begin
            r_state <= IDLE;
            r_gnt   <= 2'b00;
          end
        end
        ACCESS: begin
          r_state     <= RESP;
          r_gnt       <= 2'b00;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          r_rdata     <= (r_legal && !r_we) ? mem_rdata : 32'd0;
          r_done      <= w_id_onehot;
          r_err       <= r_legal ? 2'b00 : w_id_onehot;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign cpu.gnt   = r_gnt[0];
  assign cpu.done  = r_done[0];
  assign cpu.err   = r_err[0];
  assign dbg.gnt   = r_gnt[1];
  assign dbg.done  = r_done[1];
  assign dbg.err   = r_err[1];
  assign rdata     = r_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;

endmodule
